ysyx_23060124_axi_rd_sram: RTL

AXI4 read-only responder, the slave end of the instruction-fetch burst reads issued by the ifu cache. It serves single and burst reads (ARLEN up to 255) from an internal word-addressed memory array, with a programmable first-beat latency. A backdoor write port loads contents for boot images and benches. All AW/W/B traffic is out of scope.

---
 rtl/ysyx_23060124_axi_rd_sram.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060124_axi_rd_sram.sv
// AXI4 read-only responder backed by a word-addressed array, serving the ifu cache burst fetches.
// Array contents arrive through the mem_we side port; only the AR and R channels exist.
module ysyx_23060124_axi_rd_sram #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h2000_0000,
  parameter int                    LATENCY     = 2,
  localparam int                   IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  input  logic [3:0]            S_AXI_ARID,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic [2:0]            S_AXI_ARSIZE,
  input  logic [1:0]            S_AXI_ARBURST,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [3:0]            S_AXI_RID,
  output logic                  S_AXI_RLAST,
  input  logic                  mem_we,
  input  logic [IDX_W-1:0]      mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [3:0]          LAT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ADDR_WIDTH:0] ADDR_LO  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] ADDR_HI  = ADDR_LO + (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [3:0]              id_q, id_d;
  logic [3:0]              lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  // Beat preparation request: which address/attributes to evaluate this cycle.
  logic                    ld_en;
  logic [ADDR_WIDTH-1:0]   ld_addr;
  logic [2:0]              ld_size;
  logic [1:0]              ld_burst;
  logic [ADDR_WIDTH-1:0]   ld_offset;
  logic [IDX_W-1:0]        ld_idx;
  logic                    ld_in_range;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic [1:0]              beat_resp;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
  // contents are defined only by backdoor writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // NOTE: every variable is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    id_d       = id_q;
    beat_cnt_d = beat_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    ld_en      = 1'b0;
    ld_addr    = addr_q;
    ld_size    = size_q;
    ld_burst   = burst_q;

    case (state_q)
      IDLE: begin
        if (S_AXI_ARVALID) begin
          addr_d     = S_AXI_ARADDR;
          len_d      = S_AXI_ARLEN;
          size_d     = S_AXI_ARSIZE;
          burst_d    = S_AXI_ARBURST;
          id_d       = S_AXI_ARID;
          beat_cnt_d = 8'd0;
          if (LATENCY == 0) begin
            // Zero latency: the first beat is evaluated straight from the AR inputs.
            state_d  = BURST;
            ld_en    = 1'b1;
            ld_addr  = S_AXI_ARADDR;
            ld_size  = S_AXI_ARSIZE;
            ld_burst = S_AXI_ARBURST;
          end else begin
            state_d   = WAIT;
            lat_cnt_d = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = BURST;
          ld_en   = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      BURST: begin
        if (S_AXI_RREADY) begin
          if (beat_cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (burst_q == BURST_INCR) begin
              addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
            end
            ld_en   = 1'b1;
            ld_addr = addr_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-beat response: protocol errors outrank address decode errors.
  always_comb begin
    ld_offset   = ld_addr - BASE_ADDR;
    ld_idx      = IDX_W'(ld_offset >> 2);
    ld_in_range = ({1'b0, ld_addr} >= ADDR_LO) && ({1'b0, ld_addr} < ADDR_HI);
    beat_data   = '0;
    beat_resp   = RESP_OKAY;
    if ((ld_size > 3'd2) || ld_burst[1]) begin
      beat_resp = RESP_SLVERR;
    end else if (!ld_in_range) begin
      beat_resp = RESP_DECERR;
    end else begin
      beat_data = mem[ld_idx];
    end
  end

  always_comb begin
    rdata_d = ld_en ? beat_data : rdata_q;
    rresp_d = ld_en ? beat_resp : rresp_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, which also gives read-before-write against the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
      lat_cnt_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      id_q       <= id_d;
      beat_cnt_q <= beat_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign S_AXI_ARREADY = (state_q == IDLE);
  assign S_AXI_RVALID  = (state_q == BURST);
  assign S_AXI_RLAST   = (state_q == BURST) && (beat_cnt_q == len_q);
  assign S_AXI_RID     = id_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule
